// File: rtl/dmem_arbiter_pkg.sv
// Shared owner encodings and sizing helper for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with clear; clear wins over increment.
// at_max is a registered-state decode, usable in the same cycle's grant logic.
module arb_sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q >= MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between CPU and host loader; grant is combinational,
// load data returns one cycle after grant, and a losing CPU request stalls the pc.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int HOST_BURST_MAX = 8,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int RUN_W  = cnt_width(HOST_BURST_MAX);
  localparam int WAIT_W = cnt_width(STARVE_LIMIT);

  owner_e            last_owner_q, last_owner_d;
  logic              host_pick;
  logic              run_at_max, wait_at_max, wait_inc;
  logic [RUN_W-1:0]  run_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              unused_cnt;
  logic              cpu_rvalid_q, host_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

  // Host wins contention only when starved or while continuing an uncapped burst.
  always_comb begin
    host_pick = 1'b0;
    if (host_req) begin
      if (!cpu_req || wait_at_max) begin
        host_pick = 1'b1;
      end else if (last_owner_q == OWN_HOST && !run_at_max) begin
        host_pick = 1'b1;
      end
    end
  end

  assign host_gnt  = !rst && host_pick;
  assign cpu_gnt   = !rst && cpu_req && !host_pick;
  assign cpu_stall = cpu_req && !cpu_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_we    = host_we;
      mem_wdata = host_wdata;
    end
  end

  always_comb begin
    last_owner_d = OWN_NONE;
    if (cpu_gnt) begin
      last_owner_d = OWN_CPU;
    end else if (host_gnt) begin
      last_owner_d = OWN_HOST;
    end
  end

  // A host that drops its request forfeits any accumulated wait credit.
  assign wait_inc = host_req && !host_gnt;

  arb_sat_counter #(.WIDTH(RUN_W), .MAX(HOST_BURST_MAX)) u_host_run (
    .clk    (clk),
    .rst    (rst),
    .inc    (host_gnt),
    .clr    (!host_gnt),
    .count  (run_cnt),
    .at_max (run_at_max)
  );

  arb_sat_counter #(.WIDTH(WAIT_W), .MAX(STARVE_LIMIT)) u_host_wait (
    .clk    (clk),
    .rst    (rst),
    .inc    (wait_inc),
    .clr    (!wait_inc),
    .count  (wait_cnt),
    .at_max (wait_at_max)
  );

  assign unused_cnt = ^{run_cnt, wait_cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q  <= OWN_NONE;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      last_owner_q  <= last_owner_d;
      cpu_rvalid_q  <= cpu_gnt && !cpu_we;
      host_rvalid_q <= host_gnt && !host_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (host_gnt && !host_we) begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory attached.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BM = 8;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_BURST_MAX(BM), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic set_cpu(input logic req, input logic we, input int addr, input logic [DW-1:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_host(input logic req, input logic we, input int addr, input logic [DW-1:0] wd);
    host_req = req; host_we = we; host_addr = addr; host_wdata = wd;
  endtask

  task automatic go_idle();
    @(negedge clk);
    set_cpu(0, 0, 0, '0);
    set_host(0, 0, 0, '0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_host(1, 1, 9, 32'hDEAD);
    set_cpu(1, 1, 10, 32'hBEEF);
    #1;
    n_cmp++; if (host_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_host_gnt got=%b want=0", host_gnt); end
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_gnt got=%b want=0", cpu_gnt); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_stall got=%b want=1", cpu_stall); end
    @(negedge clk);
    rst = 1'b0;
    set_cpu(0, 0, 0, '0);
    set_host(0, 0, 0, '0);
    #1;
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_rvalid got=%b want=0", cpu_rvalid); end
    n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_host_rvalid got=%b want=0", host_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_cpu_rdata got=%h want=0", cpu_rdata); end
    n_cmp++; if (host_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_host_rdata got=%h want=0", host_rdata); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_idle_addr got=%h want=0", mem_addr); end
    n_cmp++; if (mem[9] !== 32'h11) begin n_bad++; $display("FAIL rst_dropped_host_write got=%h want=11", mem[9]); end
    n_cmp++; if (mem[10] !== 32'h22) begin n_bad++; $display("FAIL rst_dropped_cpu_write got=%h want=22", mem[10]); end
  endtask

  task automatic test_cpu_load();
    @(negedge clk);
    set_cpu(1, 0, 5, '0);
    #1;
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL ld_cpu_gnt got=%b want=1", cpu_gnt); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL ld_cpu_stall got=%b want=0", cpu_stall); end
    n_cmp++; if (mem_addr !== 32'd5) begin n_bad++; $display("FAIL ld_mem_addr got=%h want=5", mem_addr); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL ld_mem_we got=%b want=0", mem_we); end
    @(negedge clk);
    set_cpu(0, 0, 0, '0);
    #1;
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_bad++; $display("FAIL ld_cpu_rvalid got=%b want=1", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'hA5) begin n_bad++; $display("FAIL ld_cpu_rdata got=%h want=a5", cpu_rdata); end
    n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL ld_host_rvalid got=%b want=0", host_rvalid); end
    @(negedge clk);
    #1;
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL ld_rvalid_pulse got=%b want=0", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'hA5) begin n_bad++; $display("FAIL ld_rdata_hold got=%h want=a5", cpu_rdata); end
  endtask

  task automatic test_host_write();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_host(1, 1, i, 32'(i + 1));
      #1;
      n_cmp++; if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL wr_host_gnt[%0d] got=%b want=1", i, host_gnt); end
      n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_mem_we[%0d] got=%b want=1", i, mem_we); end
      n_cmp++; if (mem_addr !== 32'(i)) begin n_bad++; $display("FAIL wr_mem_addr[%0d] got=%h want=%h", i, mem_addr, i); end
      n_cmp++; if (mem_wdata !== 32'(i + 1)) begin n_bad++; $display("FAIL wr_mem_wdata[%0d] got=%h want=%h", i, mem_wdata, i + 1); end
      if (i > 0) begin
        n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rvalid[%0d] got=%b want=0", i, host_rvalid); end
      end
    end
    // Back-to-back host loads read the burst back, one rvalid per cycle.
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) set_host(1, 0, k, '0);
      else set_host(0, 0, 0, '0);
      #1;
      if (k == 0) begin
        n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rb_after_write got=%b want=0", host_rvalid); end
      end else begin
        n_cmp++; if (host_rvalid !== 1'b1) begin n_bad++; $display("FAIL rb_rvalid[%0d] got=%b want=1", k - 1, host_rvalid); end
        n_cmp++; if (host_rdata !== 32'(k)) begin n_bad++; $display("FAIL rb_rdata[%0d] got=%h want=%h", k - 1, host_rdata, k); end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rb_rvalid_end got=%b want=0", host_rvalid); end
  endtask

  task automatic test_starve();
    go_idle();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      set_cpu(1, 0, 5, '0);
      set_host(1, 0, 3, '0);
      #1;
      n_cmp++; if (cpu_gnt !== (c < 4)) begin n_bad++; $display("FAIL st_cpu_gnt[%0d] got=%b want=%b", c, cpu_gnt, c < 4); end
      n_cmp++; if (host_gnt !== (c == 4)) begin n_bad++; $display("FAIL st_host_gnt[%0d] got=%b want=%b", c, host_gnt, c == 4); end
      n_cmp++; if (cpu_stall !== (c == 4)) begin n_bad++; $display("FAIL st_cpu_stall[%0d] got=%b want=%b", c, cpu_stall, c == 4); end
      n_cmp++; if (mem_addr !== ((c < 4) ? 32'd5 : 32'd3)) begin n_bad++; $display("FAIL st_mem_addr[%0d] got=%h", c, mem_addr); end
    end
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_bad++; $display("FAIL st_cpu_rvalid got=%b want=1", cpu_rvalid); end
    go_idle();
    #1;
    n_cmp++; if (host_rvalid !== 1'b1) begin n_bad++; $display("FAIL st_host_rvalid got=%b want=1", host_rvalid); end
    n_cmp++; if (host_rdata !== 32'd4) begin n_bad++; $display("FAIL st_host_rdata got=%h want=4", host_rdata); end
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL st_cpu_rvalid_off got=%b want=0", cpu_rvalid); end
  endtask

  task automatic test_burst_cap();
    go_idle();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      set_host(1, 0, 0, '0);
      if (c > 0) set_cpu(1, 1, 20, 32'hC0FFEE);
      #1;
      n_cmp++; if (host_gnt !== (c < 8)) begin n_bad++; $display("FAIL bu_host_gnt[%0d] got=%b want=%b", c, host_gnt, c < 8); end
      n_cmp++; if (cpu_gnt !== (c == 8)) begin n_bad++; $display("FAIL bu_cpu_gnt[%0d] got=%b want=%b", c, cpu_gnt, c == 8); end
      if (c >= 1 && c < 8) begin
        n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL bu_cpu_stall[%0d] got=%b want=1", c, cpu_stall); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL bu_we_leak[%0d] got=%b want=0", c, mem_we); end
      end
    end
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL bu_cpu_we got=%b want=1", mem_we); end
    n_cmp++; if (mem_addr !== 32'd20) begin n_bad++; $display("FAIL bu_cpu_addr got=%h want=14", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hC0FFEE) begin n_bad++; $display("FAIL bu_cpu_wdata got=%h want=c0ffee", mem_wdata); end
    go_idle();
    #1;
    n_cmp++; if (mem[20] !== 32'hC0FFEE) begin n_bad++; $display("FAIL bu_mem20 got=%h want=c0ffee", mem[20]); end
  endtask

  task automatic test_reset_mid();
    go_idle();
    @(negedge clk); set_host(1, 1, 30, 32'h30);
    @(negedge clk); set_host(1, 1, 31, 32'h31);
    @(negedge clk); set_host(1, 0, 30, '0);
    @(negedge clk);
    rst = 1'b1;
    set_host(1, 1, 40, 32'hBAD);
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rm_mem_we got=%b want=0", mem_we); end
    n_cmp++; if (host_gnt !== 1'b0) begin n_bad++; $display("FAIL rm_host_gnt got=%b want=0", host_gnt); end
    @(negedge clk);
    rst = 1'b0;
    set_cpu(1, 0, 5, '0);
    set_host(1, 0, 31, '0);
    #1;
    n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_host_rvalid got=%b want=0", host_rvalid); end
    n_cmp++; if (host_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_host_rdata got=%h want=0", host_rdata); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_cpu_rdata got=%h want=0", cpu_rdata); end
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL rm_cpu_wins got=%b want=1", cpu_gnt); end
    n_cmp++; if (host_gnt !== 1'b0) begin n_bad++; $display("FAIL rm_host_loses got=%b want=0", host_gnt); end
    go_idle();
    #1;
    n_cmp++; if (mem[40] !== 32'h40) begin n_bad++; $display("FAIL rm_mem40 got=%h want=40", mem[40]); end
    n_cmp++; if (mem[31] !== 32'h31) begin n_bad++; $display("FAIL rm_mem31 got=%h want=31", mem[31]); end
  endtask

  task automatic test_random();
    int cs = 0;
    int hs = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      set_cpu($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom_range(64, 127), $urandom);
      set_host($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(128, 191), $urandom);
      #1;
      n_cmp++; if ((cpu_gnt & host_gnt) !== 1'b0) begin n_bad++; $display("FAIL rnd_both_gnt[%0d] cpu=%b host=%b", n, cpu_gnt, host_gnt); end
      if (cpu_req && !host_req) begin
        n_cmp++; if (cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL rnd_cpu_alone[%0d] got=%b want=1", n, cpu_gnt); end
      end
      if (host_req && !cpu_req) begin
        n_cmp++; if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL rnd_host_alone[%0d] got=%b want=1", n, host_gnt); end
      end
      if (host_req && cpu_req) begin
        n_cmp++; if ((cpu_gnt | host_gnt) !== 1'b1) begin n_bad++; $display("FAIL rnd_no_gnt[%0d] got=0 want=1", n); end
      end
      if (!host_req && !cpu_req) begin
        n_cmp++; if ({mem_we, mem_addr} !== 33'h0) begin n_bad++; $display("FAIL rnd_idle_bus[%0d] we=%b addr=%h want=0", n, mem_we, mem_addr); end
      end
      cs = (cpu_req && !cpu_gnt) ? cs + 1 : 0;
      hs = (host_req && !host_gnt) ? hs + 1 : 0;
      n_cmp++; if (cs > BM) begin n_bad++; $display("FAIL rnd_cpu_stall_run[%0d] got=%0d max=%0d", n, cs, BM); end
      n_cmp++; if (hs > SL + BM) begin n_bad++; $display("FAIL rnd_host_wait_run[%0d] got=%0d max=%0d", n, hs, SL + BM); end
    end
    go_idle();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = '0;
    mem[5]  = 32'hA5;
    mem[9]  = 32'h11;
    mem[10] = 32'h22;
    mem[40] = 32'h40;
    test_reset();
    test_cpu_load();
    test_host_write();
    test_starve();
    test_burst_cap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
